// File: rtl/scr1_wb_resp_pkg.sv
// Shared types for the Wishbone memory responder.
//   wb_state_e : responder FSM states
//   wb_dec_e   : address decode result (SRAM, MMIO window, error)
//   MMIO_OFF_* : byte offsets of the three MMIO words from MMIO_BASE
package scr1_wb_resp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_STALL = 2'd1,
        ST_RESP  = 2'd2
    } wb_state_e;

    typedef enum logic [1:0] {
        DEC_MEM  = 2'd0,
        DEC_MMIO = 2'd1,
        DEC_ERR  = 2'd2
    } wb_dec_e;

    localparam logic [31:0] MMIO_OFF_SOFT_IRQ = 32'h0;
    localparam logic [31:0] MMIO_OFF_EXT_IRQ  = 32'h4;
    localparam logic [31:0] MMIO_OFF_CYCLE    = 32'h8;

endpackage

// File: rtl/scr1_wb_mem_resp_if.sv
// Wishbone classic data port between one SCR1 initiator and the responder.
//   wbd_stb_i/adr_i/we_i/dat_i/sel_i : request, driven by the master
//   wbd_dat_o/ack_o/err_o            : response, driven by the slave
interface scr1_wb_mem_resp_if #(
    parameter int WB_W = 32
);
    logic            wbd_stb_i;
    logic [WB_W-1:0] wbd_adr_i;
    logic            wbd_we_i;
    logic [WB_W-1:0] wbd_dat_i;
    logic [3:0]      wbd_sel_i;
    logic [WB_W-1:0] wbd_dat_o;
    logic            wbd_ack_o;
    logic            wbd_err_o;

    modport master (
        output wbd_stb_i, wbd_adr_i, wbd_we_i, wbd_dat_i, wbd_sel_i,
        input  wbd_dat_o, wbd_ack_o, wbd_err_o
    );

    modport slave (
        input  wbd_stb_i, wbd_adr_i, wbd_we_i, wbd_dat_i, wbd_sel_i,
        output wbd_dat_o, wbd_ack_o, wbd_err_o
    );
endinterface

// File: rtl/scr1_wb_sram_bram.sv
// Synchronous single-port RAM with per-byte write enables and a registered
// read port (read-before-write on a same-cycle write). Contents are not reset.
//   clk   : clock
//   addr  : word address
//   be    : byte write enables
//   wdata : write data
//   rdata : data of addr sampled at the previous edge
module scr1_wb_sram_bram #(
    parameter int AW = 14,
    parameter int DW = 32
) (
    input  logic            clk,
    input  logic [AW-1:0]   addr,
    input  logic [DW/8-1:0] be,
    input  logic [DW-1:0]   wdata,
    output logic [DW-1:0]   rdata
);
    logic [DW-1:0] mem [0:(1<<AW)-1];

    always_ff @(posedge clk) begin
        for (int i = 0; i < DW/8; i++) begin
            if (be[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
        end
        rdata <= mem[addr];
    end
endmodule

// File: rtl/scr1_wb_mem_resp.sv
// Wishbone classic responder terminating one SCR1 imem/dmem port: byte-enabled
// SRAM at 0x0, a 3-word MMIO window (soft IRQ, ext IRQ, cycle counter), and a
// programmable ack stall. Bad addresses or an empty select terminate with err.
//   wb_clk, wb_rst : clock, synchronous active-high reset
//   stall_cfg      : extra wait cycles before ack/err, latched with the request
//   wbd            : Wishbone slave port
//   soft_irq_o     : MMIO word 0 bit0
//   ext_irq_o      : MMIO word 1 bit0
module scr1_wb_mem_resp
    import scr1_wb_resp_pkg::*;
#(
    parameter int              WB_W           = 32,
    parameter int              MEM_POWER_SIZE = 16,
    parameter logic [WB_W-1:0] MMIO_BASE      = 32'hF000_0000,
    parameter int              STALL_W        = 4
) (
    input  logic               wb_clk,
    input  logic               wb_rst,
    input  logic [STALL_W-1:0] stall_cfg,
    scr1_wb_mem_resp_if.slave  wbd,
    output logic               soft_irq_o,
    output logic               ext_irq_o
);
    wb_state_e         state;
    wb_dec_e           dec_q;
    logic              err_q;
    logic              we_q;
    logic [WB_W-1:2]   adr_q;
    logic [WB_W-1:0]   dat_q;
    logic [3:0]        sel_q;
    logic [STALL_W-1:0] cnt;
    logic [WB_W-1:0]   cycle_cnt;
    logic [WB_W-1:0]   mmio_rdata;
    logic [WB_W-1:0]   sram_rdata;

    logic [WB_W-1:2]   cur_wadr;
    logic [WB_W-1:0]   cur_off;
    logic [WB_W-1:0]   mmio_rd;
    logic              go_resp;
    logic [3:0]        sram_be;
    logic              unused_adr_lsb;

    assign unused_adr_lsb = ^wbd.wbd_adr_i[1:0];

    function automatic wb_dec_e decode(input logic [WB_W-1:2] wadr);
        logic [WB_W-1:0] off;
        off = {wadr, 2'b00} - MMIO_BASE;
        if (wadr[WB_W-1:MEM_POWER_SIZE] == '0) return DEC_MEM;
        if (off == MMIO_OFF_SOFT_IRQ || off == MMIO_OFF_EXT_IRQ || off == MMIO_OFF_CYCLE)
            return DEC_MMIO;
        return DEC_ERR;
    endfunction

    // The SRAM reads on the edge that enters RESP, so its address must come
    // straight from the bus when a zero-stall request is taken from IDLE.
    always_comb begin
        cur_wadr = (state == ST_IDLE) ? wbd.wbd_adr_i[WB_W-1:2] : adr_q;
        cur_off  = {cur_wadr, 2'b00} - MMIO_BASE;
        mmio_rd  = '0;
        if (cur_off == MMIO_OFF_SOFT_IRQ)     mmio_rd = {{(WB_W-1){1'b0}}, soft_irq_o};
        else if (cur_off == MMIO_OFF_EXT_IRQ) mmio_rd = {{(WB_W-1){1'b0}}, ext_irq_o};
        else if (cur_off == MMIO_OFF_CYCLE)   mmio_rd = cycle_cnt;
    end

    assign go_resp = (state == ST_IDLE  && wbd.wbd_stb_i && stall_cfg == '0) ||
                     (state == ST_STALL && cnt == STALL_W'(1));

    // Reset is folded in so an aborted RESP cycle never commits its write.
    assign sram_be = (state == ST_RESP && we_q && !err_q && dec_q == DEC_MEM && !wb_rst)
                     ? sel_q : 4'b0000;

    scr1_wb_sram_bram #(
        .AW (MEM_POWER_SIZE-2),
        .DW (WB_W)
    ) u_sram (
        .clk   (wb_clk),
        .addr  (cur_wadr[MEM_POWER_SIZE-1:2]),
        .be    (sram_be),
        .wdata (dat_q),
        .rdata (sram_rdata)
    );

    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            err_q      <= 1'b0;
            soft_irq_o <= 1'b0;
            ext_irq_o  <= 1'b0;
            cycle_cnt  <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 1'b1;
            if (go_resp) mmio_rdata <= mmio_rd;
            case (state)
                ST_IDLE: begin
                    if (wbd.wbd_stb_i) begin
                        adr_q <= wbd.wbd_adr_i[WB_W-1:2];
                        we_q  <= wbd.wbd_we_i;
                        dat_q <= wbd.wbd_dat_i;
                        sel_q <= wbd.wbd_sel_i;
                        dec_q <= decode(wbd.wbd_adr_i[WB_W-1:2]);
                        err_q <= (decode(wbd.wbd_adr_i[WB_W-1:2]) == DEC_ERR) ||
                                 (wbd.wbd_sel_i == 4'b0000);
                        cnt   <= stall_cfg;
                        state <= (stall_cfg == '0) ? ST_RESP : ST_STALL;
                    end
                end
                ST_STALL: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == STALL_W'(1)) state <= ST_RESP;
                end
                ST_RESP: begin
                    state <= ST_IDLE;
                    // Only bit0 of the IRQ words is writable; the counter ignores writes.
                    if (we_q && !err_q && dec_q == DEC_MMIO && sel_q[0]) begin
                        if (cur_off == MMIO_OFF_SOFT_IRQ) soft_irq_o <= dat_q[0];
                        if (cur_off == MMIO_OFF_EXT_IRQ)  ext_irq_o  <= dat_q[0];
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign wbd.wbd_ack_o = (state == ST_RESP) && !err_q;
    assign wbd.wbd_err_o = (state == ST_RESP) &&  err_q;
    assign wbd.wbd_dat_o = wbd.wbd_ack_o ? ((dec_q == DEC_MEM) ? sram_rdata : mmio_rdata) : '0;

endmodule

// File: tb/tb_scr1_wb_mem_resp.sv
module tb_scr1_wb_mem_resp;
    logic       wb_clk = 1'b0;
    logic       wb_rst = 1'b1;
    logic [3:0] stall_cfg = 4'd0;
    logic       soft_irq_o, ext_irq_o;
    int         n_chk = 0;
    int         n_err = 0;
    int         tb_cyc = 0;

    scr1_wb_mem_resp_if #(.WB_W(32)) wbd ();

    scr1_wb_mem_resp #(
        .WB_W           (32),
        .MEM_POWER_SIZE (16),
        .MMIO_BASE      (32'hF000_0000),
        .STALL_W        (4)
    ) dut (
        .wb_clk     (wb_clk),
        .wb_rst     (wb_rst),
        .stall_cfg  (stall_cfg),
        .wbd        (wbd),
        .soft_irq_o (soft_irq_o),
        .ext_irq_o  (ext_irq_o)
    );

    always #5 wb_clk = ~wb_clk;
    always @(posedge wb_clk) tb_cyc <= tb_cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One bus access; lat counts cycles from the edge that samples stb to the
    // cycle in which ack/err is seen; tail is ack|err one cycle later.
    task automatic xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel, input logic [3:0] stall,
                        output logic [31:0] rdat, output logic ack, output logic err,
                        output int lat, output logic tail, output int cyc);
        logic got;
        got = 1'b0; ack = 1'b0; err = 1'b0; rdat = '0; lat = 0; cyc = 0;
        @(negedge wb_clk);
        stall_cfg = stall;
        wbd.wbd_stb_i = 1'b1; wbd.wbd_we_i = we; wbd.wbd_adr_i = adr;
        wbd.wbd_dat_i = dat;  wbd.wbd_sel_i = sel;
        @(posedge wb_clk);
        #1 stall_cfg = 4'hF;   // must be ignored once latched
        while (!got && lat < 40) begin
            @(negedge wb_clk);
            lat++;
            if (wbd.wbd_ack_o || wbd.wbd_err_o) begin
                got = 1'b1; ack = wbd.wbd_ack_o; err = wbd.wbd_err_o;
                rdat = wbd.wbd_dat_o; cyc = tb_cyc;
            end
        end
        wbd.wbd_stb_i = 1'b0; wbd.wbd_we_i = 1'b0;
        stall_cfg = 4'd0;
        @(negedge wb_clk);
        tail = wbd.wbd_ack_o | wbd.wbd_err_o;
    endtask

    task automatic txn(input string tag, input logic we, input logic [31:0] adr,
                       input logic [31:0] dat, input logic [3:0] sel, input logic [3:0] stall,
                       input logic exp_ack, input int exp_lat, input logic [31:0] exp_dat);
        logic [31:0] rdat; logic ack, err, tail; int lat, cyc;
        xfer(we, adr, dat, sel, stall, rdat, ack, err, lat, tail, cyc);
        check({tag, "_ack"},  32'(ack), 32'(exp_ack));
        check({tag, "_err"},  32'(err), 32'(!exp_ack));
        check({tag, "_lat"},  32'(lat), 32'(exp_lat));
        check({tag, "_tail"}, 32'(tail), 32'd0);
        if (!we || !exp_ack) check({tag, "_dat"}, rdat, exp_dat);
    endtask

    // Request with stall 5, then reset while it is still stalling.
    task automatic abort_txn(input string tag, input logic we, input logic [31:0] adr,
                             input logic [31:0] dat);
        logic seen;
        @(negedge wb_clk);
        stall_cfg = 4'd5;
        wbd.wbd_stb_i = 1'b1; wbd.wbd_we_i = we; wbd.wbd_adr_i = adr;
        wbd.wbd_dat_i = dat;  wbd.wbd_sel_i = 4'hF;
        @(posedge wb_clk);
        @(posedge wb_clk);
        @(negedge wb_clk);
        wb_rst = 1'b1; wbd.wbd_stb_i = 1'b0; wbd.wbd_we_i = 1'b0; stall_cfg = 4'd0;
        @(negedge wb_clk);
        wb_rst = 1'b0;
        seen = 1'b0;
        repeat (10) begin
            @(negedge wb_clk);
            seen = seen | wbd.wbd_ack_o | wbd.wbd_err_o;
        end
        check({tag, "_noresp"}, 32'(seen), 32'd0);
        check({tag, "_soft"},   32'(soft_irq_o), 32'd0);
        check({tag, "_ext"},    32'(ext_irq_o), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] d1, d2; logic a1, a2, e1, e2, t1, t2; int l1, l2, c1, c2;
        wbd.wbd_stb_i = 1'b0; wbd.wbd_we_i = 1'b0; wbd.wbd_adr_i = '0;
        wbd.wbd_dat_i = '0;   wbd.wbd_sel_i = '0;
        repeat (3) @(negedge wb_clk);
        check("rst_ack",  32'(wbd.wbd_ack_o), 32'd0);
        check("rst_err",  32'(wbd.wbd_err_o), 32'd0);
        check("rst_dat",  wbd.wbd_dat_o, 32'd0);
        check("rst_soft", 32'(soft_irq_o), 32'd0);
        check("rst_ext",  32'(ext_irq_o), 32'd0);
        wb_rst = 1'b0;
        @(negedge wb_clk);

        // SRAM basic access and stall latency
        txn("wr0",    1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 4'hF, 4'd0, 1'b1, 1, 32'h0);
        txn("rd0",    1'b0, 32'h0000_0100, 32'h0,         4'hF, 4'd0, 1'b1, 1, 32'hDEAD_BEEF);
        txn("rd_st3", 1'b0, 32'h0000_0100, 32'h0,         4'h1, 4'd3, 1'b1, 4, 32'hDEAD_BEEF);
        txn("rd_st1", 1'b0, 32'h0000_0102, 32'h0,         4'h0 | 4'h8, 4'd1, 1'b1, 2, 32'hDEAD_BEEF);

        // byte enables
        txn("wr_be",  1'b1, 32'h0000_0100, 32'h1122_3344, 4'b0101, 4'd0, 1'b1, 1, 32'h0);
        txn("rd_be",  1'b0, 32'h0000_0100, 32'h0,         4'hF,    4'd2, 1'b1, 3, 32'hDE22_BE44);

        // error terminations leave memory alone
        txn("rd_oob", 1'b0, 32'h0002_0000, 32'h0,         4'hF, 4'd0, 1'b0, 1, 32'h0);
        txn("wr_oob", 1'b1, 32'h0002_0100, 32'hFFFF_FFFF, 4'hF, 4'd0, 1'b0, 1, 32'h0);
        txn("wr_sel0",1'b1, 32'h0000_0100, 32'h0000_0000, 4'h0, 4'd2, 1'b0, 3, 32'h0);
        txn("rd_keep",1'b0, 32'h0000_0100, 32'h0,         4'hF, 4'd0, 1'b1, 1, 32'hDE22_BE44);
        txn("mmio_oob",1'b0,32'hF000_000C, 32'h0,         4'hF, 4'd0, 1'b0, 1, 32'h0);

        // MMIO interrupt bits
        txn("wr_soft1", 1'b1, 32'hF000_0000, 32'h0000_0001, 4'hF, 4'd0, 1'b1, 1, 32'h0);
        check("soft_set", 32'(soft_irq_o), 32'd1);
        check("ext_still0", 32'(ext_irq_o), 32'd0);
        txn("wr_ext1",  1'b1, 32'hF000_0004, 32'h0000_0001, 4'hF, 4'd0, 1'b1, 1, 32'h0);
        check("ext_set", 32'(ext_irq_o), 32'd1);
        txn("rd_soft",  1'b0, 32'hF000_0000, 32'h0,         4'hF, 4'd0, 1'b1, 1, 32'h0000_0001);
        txn("wr_soft0", 1'b1, 32'hF000_0000, 32'hFFFF_FFFE, 4'hF, 4'd0, 1'b1, 1, 32'h0);
        check("soft_clr", 32'(soft_irq_o), 32'd0);
        txn("wr_soft_nosel", 1'b1, 32'hF000_0000, 32'h0000_0001, 4'b1110, 4'd0, 1'b1, 1, 32'h0);
        check("soft_nosel", 32'(soft_irq_o), 32'd0);
        txn("wr_ext0",  1'b1, 32'hF000_0004, 32'h0000_0000, 4'hF, 4'd0, 1'b1, 1, 32'h0);
        check("ext_clr", 32'(ext_irq_o), 32'd0);
        txn("rd_ext",   1'b0, 32'hF000_0004, 32'h0,         4'hF, 4'd0, 1'b1, 1, 32'h0);

        // cycle counter advances one per clock
        xfer(1'b0, 32'hF000_0008, 32'h0, 4'hF, 4'd0, d1, a1, e1, l1, t1, c1);
        repeat (7) @(negedge wb_clk);
        xfer(1'b0, 32'hF000_0008, 32'h0, 4'hF, 4'd0, d2, a2, e2, l2, t2, c2);
        check("cyc_ack1", 32'(a1), 32'd1);
        check("cyc_ack2", 32'(a2), 32'd1);
        check("cyc_delta", d2 - d1, 32'(c2 - c1));
        txn("wr_cyc", 1'b1, 32'hF000_0008, 32'h0, 4'hF, 4'd0, 1'b1, 1, 32'h0);

        // reset during stall aborts both reads and writes
        txn("wr_soft_pre", 1'b1, 32'hF000_0000, 32'h1, 4'hF, 4'd0, 1'b1, 1, 32'h0);
        txn("wr_ext_pre",  1'b1, 32'hF000_0004, 32'h1, 4'hF, 4'd0, 1'b1, 1, 32'h0);
        abort_txn("abort_rd", 1'b0, 32'h0000_0100, 32'h0);
        txn("rd_post_rd", 1'b0, 32'h0000_0100, 32'h0, 4'hF, 4'd0, 1'b1, 1, 32'hDE22_BE44);
        abort_txn("abort_wr", 1'b1, 32'h0000_0100, 32'hCAFE_F00D);
        txn("rd_post_wr", 1'b0, 32'h0000_0100, 32'h0, 4'hF, 4'd0, 1'b1, 1, 32'hDE22_BE44);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
